// File: rtl/mul_responder_pkg.sv
// Shared types, default sizes and the elaboration check helper for the
// sequential shift-add multiplier responder.
package mul_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_BPC   = 1;
    localparam int DEF_ID_W  = 4;

    // Chunk size must be a supported power of two that tiles the operand exactly.
    function automatic bit legal_bpc(input int width, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_responder_if.sv
// Request/response bundle between a multiply requester (master) and the
// responder (slave). MUL_RESPONDER_HI_EN adds the upper product half.
interface mul_responder_if
    import mul_responder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = DEF_ID_W
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [ID_W-1:0]  req_id;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
`ifdef MUL_RESPONDER_HI_EN
    logic [WIDTH-1:0] rsp_result_hi;
`endif
    logic [ID_W-1:0]  rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_id, rsp_ready,
`ifdef MUL_RESPONDER_HI_EN
        input  rsp_result_hi,
`endif
        input  req_ready, rsp_valid, rsp_result, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_id, rsp_ready,
`ifdef MUL_RESPONDER_HI_EN
        output rsp_result_hi,
`endif
        output req_ready, rsp_valid, rsp_result, rsp_id
    );

endinterface

// File: rtl/mul_responder_step.sv
// One compute step of the shift-add multiplier: adds the partial products of
// a BPC-bit multiplier chunk into the accumulator (modulo 2^DW).
module mul_responder_step #(
    parameter int DW  = 64,
    parameter int BPC = 1
) (
    input  logic [DW-1:0]  acc,
    input  logic [DW-1:0]  a_shifted,
    input  logic [BPC-1:0] b_chunk,
    output logic [DW-1:0]  acc_next
);

    logic [DW-1:0] pp [BPC];

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
            assign pp[gi] = b_chunk[gi] ? (a_shifted << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BPC; i++) begin
            acc_next = acc_next + pp[i];
        end
    end

endmodule

// File: rtl/mul_responder.sv
// Sequential shift-add multiplier responder: accepts an operand pair, spends
// WIDTH/BITS_PER_CYCLE cycles accumulating, then holds the result until taken.
// Define MUL_RESPONDER_HI_EN to also return the upper half of the product.
module mul_responder
    import mul_responder_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BITS_PER_CYCLE = DEF_BPC,
    parameter int ID_W           = DEF_ID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_responder_if.slave    bus,
    output logic              busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef MUL_RESPONDER_HI_EN
    localparam int DW = 2 * WIDTH;
`else
    localparam int DW = WIDTH;
`endif

    generate
        if (!legal_bpc(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
            $error("mul_responder: BITS_PER_CYCLE must be 1/2/4/8 and divide WIDTH");
        end
    endgenerate

    state_t           state_reg;
    logic [DW-1:0]    acc_reg;
    logic [DW-1:0]    a_sh_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ID_W-1:0]  id_reg;
    logic [DW-1:0]    acc_next;
    logic             req_ready_int;
    logic             accept;

    mul_responder_step #(
        .DW  (DW),
        .BPC (BITS_PER_CYCLE)
    ) u_step (
        .acc       (acc_reg),
        .a_shifted (a_sh_reg),
        .b_chunk   (b_reg[BITS_PER_CYCLE-1:0]),
        .acc_next  (acc_next)
    );

    // In DONE a new request may be taken in the same cycle the result leaves.
    assign req_ready_int = (state_reg == IDLE) || ((state_reg == DONE) && bus.rsp_ready);
    assign accept        = bus.req_valid && req_ready_int;
    assign bus.req_ready = req_ready_int;
    assign busy          = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            a_sh_reg       <= '0;
            b_reg          <= '0;
            cnt_reg        <= '0;
            id_reg         <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_id     <= '0;
`ifdef MUL_RESPONDER_HI_EN
            bus.rsp_result_hi <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: ;
                BUSY: begin
                    acc_reg  <= acc_next;
                    a_sh_reg <= a_sh_reg << BITS_PER_CYCLE;
                    b_reg    <= b_reg >> BITS_PER_CYCLE;
                    if (cnt_reg == '0) begin
                        state_reg      <= DONE;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_result <= acc_next[WIDTH-1:0];
                        bus.rsp_id     <= id_reg;
`ifdef MUL_RESPONDER_HI_EN
                        bus.rsp_result_hi <= acc_next[DW-1:WIDTH];
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A capture overrides the IDLE/DONE transition above.
            if (accept) begin
                state_reg <= BUSY;
                acc_reg   <= '0;
                a_sh_reg  <= DW'(bus.req_a);
                b_reg     <= bus.req_b;
                id_reg    <= bus.req_id;
                cnt_reg   <= CNT_W'(N - 1);
            end
        end
    end

endmodule

// File: tb/tb_mul_responder.sv
// Randomised scoreboard bench for mul_responder (defaults WIDTH=64, BPC=1).
// Honours MUL_RESPONDER_HI_EN for the upper product half.
module tb_mul_responder;

    localparam int W = 64;
    localparam int N = 64;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [3:0]   id;
        int           acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_bp = 0;
    exp_t q[$];

    mul_responder_if #(.WIDTH(W), .ID_W(4)) bus ();

    mul_responder #(
        .WIDTH          (W),
        .BITS_PER_CYCLE (1),
        .ID_W           (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: expected visible state derived from outstanding requests only.
    bit valid_e, busy_e;
    always @(negedge clk) begin
        if (rst_n) begin
            valid_e = (q.size() > 0) && (cyc >= q[0].acc_cyc + N);
            busy_e  = (q.size() > 0) && (cyc >= q[0].acc_cyc);
            chk("rsp_valid", bus.rsp_valid, valid_e);
            chk("busy", busy, busy_e);
            chk("req_ready", bus.req_ready, !busy_e || (valid_e && bus.rsp_ready));
            if (valid_e && bus.rsp_valid) begin
                chk("rsp_result", bus.rsp_result, q[0].lo);
                chk("rsp_id", bus.rsp_id, q[0].id);
`ifdef MUL_RESPONDER_HI_EN
                chk("rsp_result_hi", bus.rsp_result_hi, q[0].hi);
`endif
                if (bus.rsp_ready) begin
                    $display("rsp id=%0d result=%h cycle=%0d", bus.rsp_id, bus.rsp_result, cyc + 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // All tasks start and end at posedge+1, so inputs only change there.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] id);
        bit ok;
        logic [2*W-1:0] full;
        exp_t e;
        ok = 0;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_id    = id;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 1000 && !ok; n++) begin
            if (rand_bp) bus.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            if (bus.req_ready) begin
                ok = 1;
                full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.lo = full[W-1:0];
                e.hi = full[2*W-1:W];
                e.id = id;
                e.acc_cyc = cyc + 1;
                q.push_back(e);
                $display("req id=%0d a=%h b=%h cycle=%0d", id, a, b, cyc + 1);
            end
            @(posedge clk);
            #1;
        end
        chk("req_accept_timeout", ok, 1'b1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            if (rand_bp) bus.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            if (q.size() == 0) ok = 1;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", ok, 1'b1);
    endtask

    task automatic check_reset_values();
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, '0);
        chk("rst_rsp_id", bus.rsp_id, '0);
        chk("rst_busy", busy, 1'b0);
`ifdef MUL_RESPONDER_HI_EN
        chk("rst_rsp_result_hi", bus.rsp_result_hi, '0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_id    = '0;
        bus.rsp_ready = 1'b1;
        #2;
        do_reset();

        send(64'd3, 64'd5, 4'd2);
        wait_idle();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd5);
        wait_idle();
        send(64'h1_0000_0000, 64'h1_0000_0000, 4'd7);
        wait_idle();
        send(64'd0, 64'hDEAD_BEEF, 4'd4);
        wait_idle();

        // Backpressure: result must be held for 10 cycles then taken.
        bus.rsp_ready = 1'b0;
        send(64'h1234_5678, 64'h9ABC_DEF0, 4'd9);
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = bus.rsp_valid;
            @(posedge clk);
            #1;
        end
        chk("bp_valid_timeout", seen, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Back-to-back requests with the response channel always ready.
        send(64'd7, 64'd6, 4'd1);
        send(64'd9, 64'd9, 4'd3);
        wait_idle();

        // Reset partway through a computation drops the request.
        send(64'hAAAA_5555_AAAA_5555, 64'h3, 4'd6);
        repeat (29) @(posedge clk);
        #1;
        do_reset();
        repeat (80) @(posedge clk);
        #1;
        send(64'd2, 64'd2, 4'd8);
        wait_idle();

        rand_bp = 1;
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] a, b;
            a = {$urandom, $urandom};
            b = (i % 5 == 0) ? '0 : {$urandom, $urandom};
            send(a, b, 4'($urandom_range(0, 15)));
        end
        wait_idle();
        rand_bp = 0;
        bus.rsp_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
